// File: rtl/c2h_queue_scheduler.sv
// Shares one C2H packet generator between NUM_Q DMA queues: per-queue credit
// accounting, round-robin grants with bursts, and a per-packet completion watchdog.
module c2h_queue_scheduler #(
   parameter int NUM_Q       = 4,
   parameter int QID_W       = $clog2(NUM_Q),
   parameter int TM_DSC_BITS = 16,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                         axi_aclk,
   input  logic                         axi_aresetn,
   input  logic                         enable,
   input  logic [NUM_Q-1:0]             q_en,
   input  logic                         credit_updt,
   input  logic [QID_W-1:0]             credit_qid,
   input  logic [TM_DSC_BITS-1:0]       credit_in,
   input  logic [TM_DSC_BITS-1:0]       credit_perpkt,
   input  logic [7:0]                   burst_len,
   output logic                         gen_start,
   output logic [QID_W-1:0]             gen_qid,
   input  logic                         gen_done,
   output logic [NUM_Q*TM_DSC_BITS-1:0] q_credit,
   output logic                         sched_idle,
   output logic                         sched_err
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [QID_W-1:0] LAST_Q  = QID_W'(NUM_Q - 1);

   typedef enum logic [1:0] {IDLE, START, RUN} state_t;

   state_t                   state, state_nxt;
   logic [QID_W-1:0]         gen_qid_nxt;
   logic [QID_W-1:0]         last_grant, last_grant_nxt;
   logic [7:0]               burst_cnt, burst_cnt_nxt;
   logic [WD_W-1:0]          watchdog, watchdog_nxt;
   logic [TM_DSC_BITS-1:0]   credit     [NUM_Q];
   logic [TM_DSC_BITS-1:0]   credit_nxt [NUM_Q];
   logic [TM_DSC_BITS+1:0]   credit_sum [NUM_Q];
   logic [NUM_Q-1:0]         elig;
   logic                     pick_valid;
   logic [QID_W-1:0]         pick_qid;
   logic [8:0]               burst_max;
   logic [8:0]               burst_done;

   always_comb begin
      for (int i = 0; i < NUM_Q; i++) begin
         elig[i] = enable && q_en[i] && (credit_perpkt != '0) && (credit[i] >= credit_perpkt);
      end
   end

   // Round-robin: first scan queues above last_grant, then wrap to the low ones.
   always_comb begin
      pick_valid = 1'b0;
      pick_qid   = '0;
      for (int i = 0; i < NUM_Q; i++) begin
         if (!pick_valid && elig[i] && (QID_W'(i) > last_grant)) begin
            pick_valid = 1'b1;
            pick_qid   = QID_W'(i);
         end
      end
      for (int i = 0; i < NUM_Q; i++) begin
         if (!pick_valid && elig[i]) begin
            pick_valid = 1'b1;
            pick_qid   = QID_W'(i);
         end
      end
   end

   // Two spare bits hold the carry of the return and the borrow of the debit.
   always_comb begin
      for (int i = 0; i < NUM_Q; i++) begin
         credit_sum[i] = {2'b00, credit[i]};
         if (credit_updt && (credit_qid == QID_W'(i))) begin
            credit_sum[i] = credit_sum[i] + {2'b00, credit_in};
         end
         if ((state == START) && (gen_qid == QID_W'(i))) begin
            credit_sum[i] = credit_sum[i] - {2'b00, credit_perpkt};
         end
         if (credit_sum[i][TM_DSC_BITS+1]) begin
            credit_nxt[i] = '0;
         end else if (credit_sum[i][TM_DSC_BITS]) begin
            credit_nxt[i] = '1;
         end else begin
            credit_nxt[i] = credit_sum[i][TM_DSC_BITS-1:0];
         end
      end
   end

   assign burst_max  = (burst_len == 8'd0) ? 9'd1 : {1'b0, burst_len};
   assign burst_done = {1'b0, burst_cnt} + 9'd1;

   always_comb begin
      state_nxt      = state;
      gen_qid_nxt    = gen_qid;
      last_grant_nxt = last_grant;
      burst_cnt_nxt  = burst_cnt;
      watchdog_nxt   = watchdog;
      gen_start      = 1'b0;
      sched_idle     = 1'b0;
      sched_err      = 1'b0;
      case (state)
         IDLE: begin
            sched_idle = 1'b1;
            if (pick_valid) begin
               gen_qid_nxt   = pick_qid;
               burst_cnt_nxt = '0;
               state_nxt     = START;
            end
         end
         START: begin
            gen_start    = 1'b1;
            watchdog_nxt = '0;
            state_nxt    = RUN;
         end
         RUN: begin
            // A completion in the final watchdog cycle still counts as a normal finish.
            if (gen_done) begin
               burst_cnt_nxt = burst_done[7:0];
               if ((burst_done < burst_max) && elig[gen_qid]) begin
                  state_nxt = START;
               end else begin
                  last_grant_nxt = gen_qid;
                  state_nxt      = IDLE;
               end
            end else if (watchdog == WD_LAST) begin
               sched_err      = 1'b1;
               last_grant_nxt = gen_qid;
               state_nxt      = IDLE;
            end else begin
               watchdog_nxt = watchdog + WD_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state      <= IDLE;
         gen_qid    <= '0;
         last_grant <= LAST_Q;
         burst_cnt  <= '0;
         watchdog   <= '0;
         for (int i = 0; i < NUM_Q; i++) begin
            credit[i] <= '0;
         end
      end else begin
         state      <= state_nxt;
         gen_qid    <= gen_qid_nxt;
         last_grant <= last_grant_nxt;
         burst_cnt  <= burst_cnt_nxt;
         watchdog   <= watchdog_nxt;
         for (int i = 0; i < NUM_Q; i++) begin
            credit[i] <= credit_nxt[i];
         end
      end
   end

   always_comb begin
      q_credit = '0;
      for (int i = 0; i < NUM_Q; i++) begin
         q_credit[i*TM_DSC_BITS +: TM_DSC_BITS] = credit[i];
      end
   end

endmodule

// File: tb/tb_c2h_queue_scheduler.sv
// Bench for c2h_queue_scheduler: a packet-level reference model runs beside the DUT
// and is compared every cycle, plus credit vector tables and directed corner sequences.
module tb_c2h_queue_scheduler;

   localparam int NUM_Q       = 4;
   localparam int QID_W       = 2;
   localparam int TM_DSC_BITS = 16;
   localparam int TIMEOUT_CYC = 16;
   localparam int SAT         = 65535;

   logic                         axi_aclk;
   logic                         axi_aresetn;
   logic                         enable;
   logic [NUM_Q-1:0]             q_en;
   logic                         credit_updt;
   logic [QID_W-1:0]             credit_qid;
   logic [TM_DSC_BITS-1:0]       credit_in;
   logic [TM_DSC_BITS-1:0]       credit_perpkt;
   logic [7:0]                   burst_len;
   logic                         gen_start;
   logic [QID_W-1:0]             gen_qid;
   logic                         gen_done;
   logic [NUM_Q*TM_DSC_BITS-1:0] q_credit;
   logic                         sched_idle;
   logic                         sched_err;

   typedef struct {
      int qid;
      int amount;
      int want;
   } vec_t;

   vec_t tbl[10];
   int   burst_exp[7] = '{0, 0, 0, 1, 1, 1, 0};

   int checks     = 0;
   int errors     = 0;
   int cyc        = 0;
   int done_at    = -1;
   int done_delay = 0;
   int start_log[$];
   int start_cyc[$];
   int err_cyc[$];

   // Reference model: packet in flight, its age since start and packets in this grant.
   int m_credit[NUM_Q];
   bit m_busy;
   bit m_starting;
   int m_qid;
   int m_last;
   int m_age;
   int m_pkts;

   c2h_queue_scheduler #(
      .NUM_Q       (NUM_Q),
      .QID_W       (QID_W),
      .TM_DSC_BITS (TM_DSC_BITS),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .axi_aclk      (axi_aclk),
      .axi_aresetn   (axi_aresetn),
      .enable        (enable),
      .q_en          (q_en),
      .credit_updt   (credit_updt),
      .credit_qid    (credit_qid),
      .credit_in     (credit_in),
      .credit_perpkt (credit_perpkt),
      .burst_len     (burst_len),
      .gen_start     (gen_start),
      .gen_qid       (gen_qid),
      .gen_done      (gen_done),
      .q_credit      (q_credit),
      .sched_idle    (sched_idle),
      .sched_err     (sched_err)
   );

   initial axi_aclk = 1'b0;
   always #5 axi_aclk = ~axi_aclk;

   function automatic int creditOf(int q);
      return int'(q_credit[q*TM_DSC_BITS +: TM_DSC_BITS]);
   endfunction

   task automatic checkOutput(string name, int actual, int required);
      checks++;
      if (actual != required) begin
         errors++;
         if (errors <= 40) begin
            $display("[TB] FAIL %s (cycle %0d): got %0d, required %0d", name, cyc, actual, required);
         end
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < NUM_Q; i++) m_credit[i] = 0;
      m_busy     = 1'b0;
      m_starting = 1'b0;
      m_qid      = 0;
      m_last     = NUM_Q - 1;
      m_age      = 0;
      m_pkts     = 0;
      done_at    = -1;
   endtask

   task automatic modelAdvance();
      bit el[NUM_Q];
      int nc[NUM_Q];
      int bl;
      bit was_busy;
      bit was_starting;
      was_busy     = m_busy;
      was_starting = m_starting;
      bl = (burst_len == 8'd0) ? 1 : int'(burst_len);
      for (int i = 0; i < NUM_Q; i++) begin
         el[i] = enable && q_en[i] && (credit_perpkt != 0) && (m_credit[i] >= int'(credit_perpkt));
         nc[i] = m_credit[i];
         if (credit_updt && credit_qid == i) nc[i] += int'(credit_in);
         if (was_starting && m_qid == i) nc[i] -= int'(credit_perpkt);
         if (nc[i] < 0) nc[i] = 0;
         if (nc[i] > SAT) nc[i] = SAT;
      end
      if (!was_busy) begin
         for (int k = 1; k <= NUM_Q; k++) begin
            int q;
            q = (m_last + k) % NUM_Q;
            if (!m_busy && el[q]) begin
               m_qid      = q;
               m_pkts     = 0;
               m_busy     = 1'b1;
               m_starting = 1'b1;
            end
         end
      end else if (was_starting) begin
         m_starting = 1'b0;
         m_age      = 1;
      end else if (gen_done) begin
         m_pkts++;
         if (m_pkts < bl && el[m_qid]) begin
            m_starting = 1'b1;
         end else begin
            m_last = m_qid;
            m_busy = 1'b0;
         end
      end else if (m_age == TIMEOUT_CYC) begin
         m_last = m_qid;
         m_busy = 1'b0;
      end else begin
         m_age++;
      end
      for (int i = 0; i < NUM_Q; i++) m_credit[i] = nc[i];
   endtask

   // One clock: emulate the generator, compare at the falling edge, advance the model.
   task automatic step();
      int exp_err;
      gen_done = (cyc == done_at);
      @(negedge axi_aclk);
      exp_err = (m_busy && !m_starting && !gen_done && m_age == TIMEOUT_CYC) ? 1 : 0;
      checkOutput("gen_start", int'(gen_start), int'(m_busy && m_starting));
      checkOutput("gen_qid", int'(gen_qid), m_qid);
      checkOutput("sched_idle", int'(sched_idle), int'(!m_busy));
      checkOutput("sched_err", int'(sched_err), exp_err);
      for (int i = 0; i < NUM_Q; i++) begin
         checkOutput($sformatf("q_credit%0d", i), creditOf(i), m_credit[i]);
      end
      if (gen_start) begin
         start_log.push_back(int'(gen_qid));
         start_cyc.push_back(cyc);
      end
      if (sched_err) err_cyc.push_back(cyc);
      if (m_busy && m_starting) begin
         done_at = cyc + ((done_delay > 0) ? done_delay : int'($urandom_range(20, 1)));
      end
      if (!axi_aresetn) modelReset();
      else modelAdvance();
      @(posedge axi_aclk);
      #1;
      cyc++;
   endtask

   task automatic runCycles(int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic runUntilStarts(int n, int budget, string name);
      int k;
      k = 0;
      while (start_log.size() < n && k < budget) begin
         step();
         k++;
      end
      if (start_log.size() < n) checkOutput(name, start_log.size(), n);
   endtask

   task automatic waitIdle(int budget);
      int k;
      k = 0;
      while (!sched_idle && k < budget) begin
         step();
         k++;
      end
      if (!sched_idle) checkOutput("idle_timeout", 0, 1);
   endtask

   task automatic applyStimulus(int q, int amount);
      credit_qid  = QID_W'(q);
      credit_in   = TM_DSC_BITS'(amount);
      credit_updt = 1'b1;
      step();
      credit_updt = 1'b0;
   endtask

   task automatic clearLogs();
      start_log.delete();
      start_cyc.delete();
      err_cyc.delete();
   endtask

   task automatic doReset();
      #1;
      axi_aresetn = 1'b0;
      #1;
      checkOutput("rst_gen_start", int'(gen_start), 0);
      checkOutput("rst_gen_qid", int'(gen_qid), 0);
      checkOutput("rst_idle", int'(sched_idle), 1);
      checkOutput("rst_err", int'(sched_err), 0);
      for (int i = 0; i < NUM_Q; i++) checkOutput("rst_credit", creditOf(i), 0);
      modelReset();
      runCycles(2);
      axi_aresetn = 1'b1;
      clearLogs();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got no finish, required finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      axi_aresetn   = 1'b0;
      enable        = 1'b0;
      q_en          = '0;
      credit_updt   = 1'b0;
      credit_qid    = '0;
      credit_in     = '0;
      credit_perpkt = '0;
      burst_len     = '0;
      gen_done      = 1'b0;
      modelReset();
      tbl[0] = '{0, 32'hFFFE, 32'hFFFE};
      tbl[1] = '{0, 5,        32'hFFFF};
      tbl[2] = '{1, 3,        3};
      tbl[3] = '{1, 0,        3};
      tbl[4] = '{2, 32'hFFFF, 32'hFFFF};
      tbl[5] = '{2, 32'hFFFF, 32'hFFFF};
      tbl[6] = '{3, 1,        1};
      tbl[7] = '{3, 32'h7FFF, 32'h8000};
      tbl[8] = '{1, 32'hFFFC, 32'hFFFF};
      tbl[9] = '{1, 1,        32'hFFFF};

      @(posedge axi_aclk);
      #1;
      checkOutput("init_gen_start", int'(gen_start), 0);
      checkOutput("init_gen_qid", int'(gen_qid), 0);
      checkOutput("init_idle", int'(sched_idle), 1);
      checkOutput("init_err", int'(sched_err), 0);
      step();
      axi_aresetn = 1'b1;
      step();

      $display("[TB] credit return and saturation table");
      q_en = '1;
      credit_perpkt = 1;
      foreach (tbl[i]) begin
         applyStimulus(tbl[i].qid, tbl[i].amount);
         checkOutput($sformatf("tbl%0d_credit", i), creditOf(tbl[i].qid), tbl[i].want);
      end

      $display("[TB] credit gating");
      doReset();
      credit_perpkt = 2;
      burst_len     = 1;
      enable        = 1'b1;
      done_delay    = 10;
      applyStimulus(2, 4);
      runCycles(60);
      checkOutput("gate_starts", start_log.size(), 2);
      for (int i = 0; i < start_log.size(); i++) checkOutput("gate_qid", start_log[i], 2);
      checkOutput("gate_credit2", creditOf(2), 0);
      checkOutput("gate_idle", int'(sched_idle), 1);

      $display("[TB] round robin");
      doReset();
      enable        = 1'b0;
      credit_perpkt = 1;
      burst_len     = 1;
      done_delay    = 3;
      for (int q = 0; q < NUM_Q; q++) applyStimulus(q, 10);
      enable = 1'b1;
      runUntilStarts(8, 200, "rr_start_timeout");
      enable = 1'b0;
      waitIdle(50);
      for (int i = 0; i < start_log.size() && i < 8; i++) checkOutput("rr_qid", start_log[i], i % NUM_Q);
      for (int q = 0; q < NUM_Q; q++) checkOutput("rr_credit", creditOf(q), 8);

      $display("[TB] bursts");
      doReset();
      burst_len  = 3;
      done_delay = 4;
      applyStimulus(0, 10);
      applyStimulus(1, 10);
      enable = 1'b1;
      runUntilStarts(7, 300, "burst_start_timeout");
      enable = 1'b0;
      waitIdle(50);
      for (int i = 0; i < start_log.size() && i < 7; i++) checkOutput("burst_qid", start_log[i], burst_exp[i]);
      if (start_cyc.size() >= 4) begin
         checkOutput("burst_gap_in", start_cyc[1] - start_cyc[0], 5);
         checkOutput("burst_gap_rot", start_cyc[3] - start_cyc[2], 6);
      end

      $display("[TB] credit return during debit");
      doReset();
      burst_len  = 1;
      done_delay = 5;
      applyStimulus(1, 3);
      enable = 1'b1;
      step();
      checkOutput("sim_start", int'(gen_start), 1);
      applyStimulus(1, 5);
      checkOutput("sim_credit1", creditOf(1), 7);
      enable = 1'b0;
      waitIdle(50);

      $display("[TB] watchdog abort");
      doReset();
      done_delay = 1000;
      applyStimulus(0, 1);
      applyStimulus(1, 1);
      enable = 1'b1;
      runUntilStarts(2, 100, "wd_start_timeout");
      enable = 1'b0;
      runCycles(25);
      checkOutput("wd_err_count", err_cyc.size(), 2);
      if (start_log.size() >= 2 && err_cyc.size() >= 1) begin
         checkOutput("wd_qid_first", start_log[0], 0);
         checkOutput("wd_qid_next", start_log[1], 1);
         checkOutput("wd_err_delay", err_cyc[0] - start_cyc[0], TIMEOUT_CYC);
         checkOutput("wd_restart", start_cyc[1] - err_cyc[0], 2);
      end
      checkOutput("wd_credit0", creditOf(0), 0);
      checkOutput("wd_credit1", creditOf(1), 0);
      checkOutput("wd_idle", int'(sched_idle), 1);

      $display("[TB] enable drop and reset mid-packet");
      doReset();
      burst_len  = 4;
      done_delay = 6;
      applyStimulus(2, 5);
      enable = 1'b1;
      runUntilStarts(1, 20, "en_start_timeout");
      runCycles(2);
      enable = 1'b0;
      runCycles(20);
      checkOutput("en_starts", start_log.size(), 1);
      checkOutput("en_credit2", creditOf(2), 4);
      checkOutput("en_idle", int'(sched_idle), 1);
      clearLogs();
      enable = 1'b1;
      runUntilStarts(1, 20, "rst_start_timeout");
      applyStimulus(0, 3);
      applyStimulus(3, 3);
      checkOutput("rst_pre_busy", int'(sched_idle), 0);
      doReset();
      enable = 1'b0;
      for (int q = 0; q < NUM_Q; q++) applyStimulus(q, 2);
      enable = 1'b1;
      runUntilStarts(1, 20, "rst_grant_timeout");
      if (start_log.size() >= 1) checkOutput("rst_first_grant", start_log[0], 0);
      enable = 1'b0;
      waitIdle(50);

      $display("[TB] randomized traffic");
      doReset();
      q_en          = '1;
      enable        = 1'b1;
      credit_perpkt = 1;
      burst_len     = 2;
      done_delay    = 0;
      for (int n = 0; n < 2000; n++) begin
         credit_updt = ($urandom_range(99, 0) < 30);
         credit_qid  = QID_W'($urandom_range(NUM_Q - 1, 0));
         credit_in   = ($urandom_range(49, 0) == 0) ? 16'hFFF0 : 16'($urandom_range(6, 0));
         if ($urandom_range(49, 0) == 0) enable = ~enable;
         if ($urandom_range(29, 0) == 0) q_en = 4'($urandom);
         if ($urandom_range(39, 0) == 0) burst_len = 8'($urandom_range(3, 0));
         if (sched_idle && $urandom_range(19, 0) == 0) credit_perpkt = 16'($urandom_range(3, 0));
         step();
      end
      credit_updt = 1'b0;
      enable      = 1'b0;
      runCycles(30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
